// File: rtl/frame_reader_pkg.sv
// Shared constants and types for the frame-buffer window reader.
// Bar colours are only used when FRAME_READER_PATTERN_EN is defined.
package frame_reader_pkg;

    localparam logic [11:0] BORDER_DEFAULT = 12'h000;

    localparam logic [11:0] BAR_COLORS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/frame_window_reader_axis_scale_counter.sv
// One raster axis: sub-pixel counter plus an accumulator that adds stride
// every SCALE steps inside the window; with stride 1 the accumulator is the index.
module axis_scale_counter
    import frame_reader_pkg::*;
#(
    parameter int unsigned SCALE  = 1,
    parameter int unsigned OFFSET = 0,
    parameter int unsigned LEN    = 160,
    parameter int unsigned AW     = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pos,
    input  logic          step,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] acc_c,
    output logic          in_range_c
);

    localparam int unsigned SUB_W = (SCALE > 1) ? clog2(SCALE) : 1;
    localparam logic [9:0]  OFF_P = 10'(OFFSET);
    localparam logic [9:0]  LIM_P = 10'(OFFSET + LEN * SCALE);

    logic [SUB_W-1:0] sub_q, sub_c;
    logic [AW-1:0]    acc_q;

    assign in_range_c = (pos >= OFF_P) && (pos < LIM_P);

    // Value for the current position, derived from the previous step's value.
    always_comb begin
        sub_c = sub_q;
        acc_c = acc_q;
        if (step && pos == OFF_P) begin
            sub_c = '0;
            acc_c = '0;
        end else if (step && pos > OFF_P && pos < LIM_P) begin
            if (sub_q == SUB_W'(SCALE - 1)) begin
                sub_c = '0;
                acc_c = acc_q + stride;
            end else begin
                sub_c = sub_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
            acc_q <= '0;
        end else begin
            sub_q <= sub_c;
            acc_q <= acc_c;
        end
    end

endmodule

// File: rtl/frame_window_reader.sv
// Maps VGA raster position to upscaled frame-buffer addresses and aligns RAM data
// with a border colour. Optional colour-bar test pattern: FRAME_READER_PATTERN_EN.
module frame_window_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned    CAM_SCREEN_X = 160,
    parameter int unsigned    CAM_SCREEN_Y = 120,
    parameter int unsigned    AW           = 15,
    parameter int unsigned    DW           = 12,
    parameter int unsigned    SCALE        = 1,
    parameter int unsigned    OFFSET_X     = 0,
    parameter int unsigned    OFFSET_Y     = 0,
    parameter logic [DW-1:0]  BORDER_COLOR = DW'(BORDER_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [9:0]    posY,
    input  logic [DW-1:0] pixelIn,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] pixelOut,
    output logic          in_window
`ifdef FRAME_READER_PATTERN_EN
    ,
    input  logic          pattern_sel
`endif
);

    localparam int unsigned BLACK = CAM_SCREEN_X * CAM_SCREEN_Y;

    if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
        $error("frame_window_reader: SCALE must be 1, 2 or 4");
    end

    state_t        state_q, state_c;
    logic [9:0]    prev_y_q;
    logic [AW-1:0] cx_c, row_c, addr_c;
    logic          x_in_c, y_in_c, win_c, win1_q;
    logic [DW-1:0] pix_data;

    axis_scale_counter #(
        .SCALE(SCALE), .OFFSET(OFFSET_X), .LEN(CAM_SCREEN_X), .AW(AW)
    ) u_x (
        .clk(clk), .rst(rst), .pos(posX), .step(1'b1), .stride(AW'(1)),
        .acc_c(cx_c), .in_range_c(x_in_c)
    );

    axis_scale_counter #(
        .SCALE(SCALE), .OFFSET(OFFSET_Y), .LEN(CAM_SCREEN_Y), .AW(AW)
    ) u_y (
        .clk(clk), .rst(rst), .pos(posY), .step(posY != prev_y_q),
        .stride(AW'(CAM_SCREEN_X)), .acc_c(row_c), .in_range_c(y_in_c)
    );

    // The (0,0) position itself already counts as running.
    always_comb begin
        state_c = state_q;
        win_c   = 1'b0;
        addr_c  = AW'(BLACK);
        if (state_q == WAIT_FRAME && posX == 10'd0 && posY == 10'd0) begin
            state_c = RUN;
        end
        if (state_c == RUN && x_in_c && y_in_c) begin
            win_c  = 1'b1;
            addr_c = row_c + cx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_FRAME;
            prev_y_q  <= '0;
            addr_out  <= AW'(BLACK);
            win1_q    <= 1'b0;
            in_window <= 1'b0;
        end else begin
            state_q   <= state_c;
            prev_y_q  <= posY;
            addr_out  <= addr_c;
            win1_q    <= win_c;
            in_window <= win1_q;
        end
    end

`ifdef FRAME_READER_PATTERN_EN
    localparam int unsigned BAND_W = CAM_SCREEN_X / 8;

    logic [2:0]    band_q, band_c;
    logic [AW-1:0] band_end_q, band_end_c;
    logic [DW-1:0] bar1_q, bar2_q;
    logic          pat1_q, pat2_q;

    // Band index steps when the column index reaches the next band boundary.
    always_comb begin
        band_c     = band_q;
        band_end_c = band_end_q;
        if (posX == 10'(OFFSET_X)) begin
            band_c     = '0;
            band_end_c = AW'(BAND_W);
        end else if (cx_c == band_end_q) begin
            band_c     = band_q + 3'd1;
            band_end_c = band_end_q + AW'(BAND_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            band_q     <= '0;
            band_end_q <= '0;
            bar1_q     <= '0;
            bar2_q     <= '0;
            pat1_q     <= 1'b0;
            pat2_q     <= 1'b0;
        end else begin
            band_q     <= band_c;
            band_end_q <= band_end_c;
            bar1_q     <= DW'(BAR_COLORS[band_c]);
            bar2_q     <= bar1_q;
            pat1_q     <= pattern_sel;
            pat2_q     <= pat1_q;
        end
    end

    assign pix_data = pat2_q ? bar2_q : pixelIn;
`else
    assign pix_data = pixelIn;
`endif

    assign pixelOut = in_window ? pix_data : BORDER_COLOR;

endmodule

// File: tb/tb_frame_window_reader.sv
// Scoreboard bench: several parameterisations driven by a randomised raster and
// checked against a position-based address/pixel model.
module tb_frame_window_reader;

`ifdef FRAME_READER_PATTERN_EN
    localparam int NDUT = 5;
`else
    localparam int NDUT = 4;
`endif

    localparam int CXT [0:4] = '{160, 160, 160, 32, 160};
    localparam int CYT [0:4] = '{120, 120, 120, 16, 120};
    localparam int ST  [0:4] = '{1,   2,   2,   4,  1};
    localparam int OXT [0:4] = '{0,   0,   160, 8,  0};
    localparam int OYT [0:4] = '{0,   0,   120, 4,  0};
    localparam logic [11:0] BORDER = 12'h1E2;

    typedef struct {int due; int d; int x; int y; logic [14:0] a;} aexp_t;
    typedef struct {int due; int d; int x; int y; logic w; logic [11:0] p;} pexp_t;

    logic        clk = 1'b0;
    logic        rst  [NDUT];
    logic [9:0]  posx [NDUT];
    logic [9:0]  posy [NDUT];
    logic [11:0] pin  [NDUT];
    logic [11:0] pout [NDUT];
    logic [14:0] addr [NDUT];
    logic        win  [NDUT];
    logic        psel [NDUT];
    bit          run  [NDUT];

    aexp_t aq[$];
    pexp_t pq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        frame_window_reader #(
            .CAM_SCREEN_X(CXT[g]), .CAM_SCREEN_Y(CYT[g]), .AW(15), .DW(12),
            .SCALE(ST[g]), .OFFSET_X(OXT[g]), .OFFSET_Y(OYT[g]),
            .BORDER_COLOR(BORDER)
        ) u_dut (
            .clk(clk), .rst(rst[g]), .posX(posx[g]), .posY(posy[g]),
            .pixelIn(pin[g]), .addr_out(addr[g]), .pixelOut(pout[g]),
            .in_window(win[g])
`ifdef FRAME_READER_PATTERN_EN
            , .pattern_sel(psel[g])
`endif
        );
    end

    function automatic logic [11:0] ram_val(input logic [14:0] a);
        return a[11:0] ^ {9'd0, a[14:12]} ^ 12'h5A3;
    endfunction

    // Registered-read frame buffer model.
    always @(posedge clk)
        for (int i = 0; i < NDUT; i++) pin[i] <= ram_val(addr[i]);

    always @(negedge clk) begin
        aexp_t ea;
        pexp_t ep;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ea = aq.pop_front();
            total++;
            if (ea.due != cyc || addr[ea.d] !== ea.a) begin
                bad++;
                $display("FAIL addr dut%0d pos(%0d,%0d): got %0d want %0d",
                         ea.d, ea.x, ea.y, addr[ea.d], ea.a);
            end
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            ep = pq.pop_front();
            total += 2;
            if (ep.due != cyc || win[ep.d] !== ep.w) begin
                bad++;
                $display("FAIL in_window dut%0d pos(%0d,%0d): got %0b want %0b",
                         ep.d, ep.x, ep.y, win[ep.d], ep.w);
            end
            if (ep.due != cyc || pout[ep.d] !== ep.p) begin
                bad++;
                $display("FAIL pixelOut dut%0d pos(%0d,%0d): got %h want %h",
                         ep.d, ep.x, ep.y, pout[ep.d], ep.p);
            end
        end
    end

    task automatic present(input int d, input int x, input int y, input bit r);
        aexp_t ea;
        pexp_t ep;
        bit    inw;
        int    col;
        @(posedge clk);
        #1;
        posx[d] = 10'(x);
        posy[d] = 10'(y);
        rst[d]  = r;
        if (r) begin
            run[d] = 1'b0;
            foreach (pq[i])
                if (pq[i].d == d && pq[i].due == cyc + 1) begin
                    pq[i].w = 1'b0;
                    pq[i].p = BORDER;
                end
        end else if (x == 0 && y == 0) begin
            run[d] = 1'b1;
        end
        inw = run[d] && !r &&
              x >= OXT[d] && x < OXT[d] + CXT[d] * ST[d] &&
              y >= OYT[d] && y < OYT[d] + CYT[d] * ST[d];
        col  = inw ? (x - OXT[d]) / ST[d] : 0;
        ea.a = inw ? 15'(col + ((y - OYT[d]) / ST[d]) * CXT[d]) : 15'(CXT[d] * CYT[d]);
        ea.due = cyc + 1; ea.d = d; ea.x = x; ea.y = y;
        ep.due = cyc + 2; ep.d = d; ep.x = x; ep.y = y;
        ep.w = inw;
        if (!inw)        ep.p = BORDER;
        else if (d == 4) ep.p = bars[col / (CXT[d] / 8)];
        else             ep.p = ram_val(ea.a);
        aq.push_back(ea);
        pq.push_back(ep);
    endtask

    function automatic bit must_full(input int d, input int y);
        case (d)
            0:       return y == 0 || y == 60 || y == 119 || y == 120;
            1:       return y == 3 || y == 100 || y == 239 || y == 240;
            2:       return y == 120 || y == 122 || y == 359 || y == 360;
            3:       return y >= 4 && y <= 68;
            default: return y <= 2 || y == 119 || y == 120;
        endcase
    endfunction

    // Full lines cover the window plus two columns; other lines are short stubs.
    task automatic frame(input int d, input int sy, input int sx);
        for (int y = 0; y < 525; y++) begin
            bit full;
            int xe;
            full = must_full(d, y) || ($urandom_range(0, 31) == 0);
            xe   = full ? OXT[d] + CXT[d] * ST[d] + 1 : 2;
            for (int x = 0; x <= xe; x++) present(d, x, y, (y == sy && x == sx));
            present(d, 799, y, 1'b0);
        end
    endtask

    initial begin
        #6_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; posx[d] = 10'd799; posy[d] = 10'd524;
            psel[d] = (d == 4); run[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            present(d, 799, 524, 1'b1);
            present(d, 799, 524, 1'b1);
            present(d, 799, 524, 1'b0);
            present(d, OXT[d] + 1, OYT[d] + 1, 1'b0);
            present(d, OXT[d] + 2, OYT[d] + 1, 1'b0);
            present(d, 799, 524, 1'b0);
            frame(d, -1, -1);
            if (d == 0) begin
                frame(0, 60, 80);
                frame(0, -1, -1);
            end
        end
        repeat (4) @(posedge clk);
        total++;
        if (aq.size() != 0 || pq.size() != 0) begin
            bad++;
            $display("FAIL drain: pending addr=%0d pix=%0d want 0", aq.size(), pq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
